// File: rtl/ps2_keyparse_pkg.sv
// Shared types and byte constants for the PS/2 scancode parser.
package ps2_keyparse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP_E1
  } state_t;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_E1     = 8'hE1;
  localparam logic [7:0] CODE_AA     = 8'hAA;
  localparam logic [7:0] CODE_FA     = 8'hFA;
  localparam logic [7:0] CODE_ERR00  = 8'h00;
  localparam logic [7:0] CODE_ERRFF  = 8'hFF;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == CODE_ERR00) || (b == CODE_ERRFF);
  endfunction

endpackage

// File: rtl/ps2_keyparse_funcmod.sv
// PS/2 scancode set-2 parser: strips E0/F0 prefixes, swallows the Pause sequence,
// tracks modifiers. Define PS2_REPEAT_FILTER_EN to drop typematic repeats.
module ps2_keyparse_funcmod
  import ps2_keyparse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int SHOW_BREAK  = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  iData,
  input  logic        iTrig,
  output logic [7:0]  oData,
  output logic        oExt,
  output logic        oBreak,
  output logic        oTrig,
  output logic [2:0]  oMod,
  output logic        oErr,
  output logic [23:0] oShow
);

  localparam int TW = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          emit, emit_ext, emit_brk, emit_ok, err_d;
  logic [7:0]    emit_code;

  logic [7:0]    data_q;
  logic          ext_q, brk_q, trig_q, err_q;
  logic          lshift_q, rshift_q, ctrl_q, alt_q;
  logic [23:0]   show_q;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    emit_code = iData;
    err_d     = 1'b0;
    if (iTrig) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_d = '0;
      if (is_err_byte(iData)) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        err_d   = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (iData == CODE_E0)      state_d = ST_GOT_E0;
            else if (iData == CODE_F0) state_d = ST_GOT_F0;
            else if (iData == CODE_E1) begin
              skip_d  = E1_SKIP_LEN;
              state_d = ST_SKIP_E1;
            end else if (iData != CODE_AA && iData != CODE_FA) emit = 1'b1;
          end
          ST_GOT_E0: begin
            if (iData == CODE_F0) state_d = ST_GOT_E0F0;
            else if (iData != CODE_E0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            if (iData == CODE_E0) state_d = ST_GOT_E0F0;
            else if (iData != CODE_F0) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_GOT_E0F0: begin
            if (iData != CODE_E0 && iData != CODE_F0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_brk = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_SKIP_E1: begin
            if (skip_q <= 3'd1) begin
              emit      = 1'b1;
              emit_code = CODE_E1;
              skip_d    = '0;
              state_d   = ST_IDLE;
            end else begin
              skip_d = skip_q - 3'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end else begin
      tmo_d = '0;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Remembers the last pressed key so typematic repeats of it are swallowed.
  logic [8:0] rpt_key_q, rpt_key_d;
  logic       rpt_vld_q, rpt_vld_d;
  logic       rpt_hit;

  always_comb begin
    rpt_key_d = rpt_key_q;
    rpt_vld_d = rpt_vld_q;
    rpt_hit   = rpt_vld_q && (rpt_key_q == {emit_ext, emit_code});
    emit_ok   = emit;
    if (emit) begin
      if (!emit_brk) begin
        if (rpt_hit) emit_ok = 1'b0;
        else begin
          rpt_key_d = {emit_ext, emit_code};
          rpt_vld_d = 1'b1;
        end
      end else if (rpt_hit) begin
        rpt_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rpt_key_q <= '0;
      rpt_vld_q <= 1'b0;
    end else begin
      rpt_key_q <= rpt_key_d;
      rpt_vld_q <= rpt_vld_d;
    end
  end
`else
  assign emit_ok = emit;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      trig_q   <= 1'b0;
      err_q    <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      show_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      trig_q  <= emit_ok;
      err_q   <= err_d;
      if (emit_ok) begin
        data_q <= emit_code;
        ext_q  <= emit_ext;
        brk_q  <= emit_brk;
        case (emit_code)
          CODE_LSHIFT: lshift_q <= !emit_brk;
          CODE_RSHIFT: rshift_q <= !emit_brk;
          CODE_CTRL:   ctrl_q   <= !emit_brk;
          CODE_ALT:    alt_q    <= !emit_brk;
          default: ;
        endcase
        if (!emit_brk || SHOW_BREAK != 0)
          show_q <= {(emit_ext ? CODE_E0 : 8'h00), (emit_brk ? CODE_F0 : 8'h00), emit_code};
      end
    end
  end

  assign oData  = data_q;
  assign oExt   = ext_q;
  assign oBreak = brk_q;
  assign oTrig  = trig_q;
  assign oErr   = err_q;
  assign oMod   = {alt_q, ctrl_q, lshift_q | rshift_q};
  assign oShow  = show_q;

endmodule

// File: tb/tb_ps2_keyparse_funcmod.sv
// Self-checking bench for ps2_keyparse_funcmod; expectations follow PS2_REPEAT_FILTER_EN.
module tb_ps2_keyparse_funcmod;

  localparam int TO = 20;
  localparam int SB = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic        iTrig = 1'b0;
  logic [7:0]  oData;
  logic        oExt, oBreak, oTrig, oErr;
  logic [2:0]  oMod;
  logic [23:0] oShow;

  ps2_keyparse_funcmod #(.TIMEOUT_CYC(TO), .SHOW_BREAK(SB)) dut (
    .CLOCK(clk), .RESET(rst_n), .iData(iData), .iTrig(iTrig),
    .oData(oData), .oExt(oExt), .oBreak(oBreak), .oTrig(oTrig),
    .oMod(oMod), .oErr(oErr), .oShow(oShow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [2:0]  mod;
    logic [23:0] show;
  } emit_t;

  typedef struct {
    logic [7:0] b;
    bit         emit;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [2:0] mod;
    bit         err;
  } vec_t;

  emit_t       sb[$];
  vec_t        tbl[$];
  emit_t       e_mon, got;
  logic [23:0] show_exp = 24'h0;
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  int          err_exp = 0;

  // Scoreboard: every DUT emit is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oErr) err_seen++;
      if (oTrig) begin
        got = {oData, oExt, oBreak, oMod, oShow};
        $display("emit code=%02h ext=%0b brk=%0b mod=%03b show=%06h", oData, oExt, oBreak, oMod, oShow);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_emit: got %h, required no emit", got);
        end else begin
          e_mon = sb.pop_front();
          if (got !== e_mon) begin
            errors++;
            $display("FAIL emit: got %h, required %h", got, e_mon);
          end
        end
      end
    end
  end

  task automatic exp_emit(input logic [7:0] code, input logic ext, input logic brk, input logic [2:0] mod);
    if (!brk || SB != 0) show_exp = {(ext ? 8'hE0 : 8'h00), (brk ? 8'hF0 : 8'h00), code};
    sb.push_back({code, ext, brk, mod, show_exp});
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    iData = b;
    iTrig = 1'b1;
    @(negedge clk);
    iTrig = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_step(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_emit: pending %0d, required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (err_seen != err_exp) begin
      errors++;
      $display("FAIL %s err_count: got %0d, required %0d", name, err_seen, err_exp);
      err_seen = err_exp;
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({oData, oExt, oBreak, oTrig, oMod, oErr, oShow} !== 39'h0) begin
      errors++;
      $display("FAIL %s reset_outputs: got %h, required 0", name,
               {oData, oExt, oBreak, oTrig, oMod, oErr, oShow});
    end
  endtask

  task automatic add_v(input logic [7:0] b, input bit em, input logic [7:0] code,
                       input logic ext, input logic brk, input logic [2:0] mod, input bit err);
    vec_t v;
    v.b = b; v.emit = em; v.code = code; v.ext = ext; v.brk = brk; v.mod = mod; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic add_p(input logic [7:0] b);
    add_v(b, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    // Make/break pairs, extended keys, modifiers, Pause, errors, ignored bytes.
    add_v(8'h1C, 1, 8'h1C, 0, 0, 3'b000, 0);
    add_p(8'hF0);
    add_v(8'h1C, 1, 8'h1C, 0, 1, 3'b000, 0);
    add_p(8'hE0);
    add_v(8'h75, 1, 8'h75, 1, 0, 3'b000, 0);
    add_p(8'hE0); add_p(8'hF0);
    add_v(8'h75, 1, 8'h75, 1, 1, 3'b000, 0);
    add_v(8'h12, 1, 8'h12, 0, 0, 3'b001, 0);
    add_v(8'h1C, 1, 8'h1C, 0, 0, 3'b001, 0);
    add_p(8'hF0);
    add_v(8'h12, 1, 8'h12, 0, 1, 3'b000, 0);
    add_p(8'hE1); add_p(8'h14); add_p(8'h77); add_p(8'hE1);
    add_p(8'hF0); add_p(8'h14); add_p(8'hF0);
    add_v(8'h77, 1, 8'hE1, 0, 0, 3'b000, 0);
    add_p(8'hE0);
    add_v(8'h14, 1, 8'h14, 1, 0, 3'b010, 0);
    add_v(8'h11, 1, 8'h11, 0, 0, 3'b110, 0);
    add_v(8'h59, 1, 8'h59, 0, 0, 3'b111, 0);
    add_p(8'hF0);
    add_v(8'h11, 1, 8'h11, 0, 1, 3'b011, 0);
    add_p(8'hE0); add_p(8'hF0);
    add_v(8'h14, 1, 8'h14, 1, 1, 3'b001, 0);
    add_p(8'hF0);
    add_v(8'h59, 1, 8'h59, 0, 1, 3'b000, 0);
    add_p(8'hF0);
    add_v(8'h00, 0, 8'h00, 0, 0, 3'b000, 1);
    add_v(8'h1C, 1, 8'h1C, 0, 0, 3'b000, 0);
    add_v(8'hFF, 0, 8'h00, 0, 0, 3'b000, 1);
    add_p(8'hE0);
    add_v(8'hFF, 0, 8'h00, 0, 0, 3'b000, 1);
    add_v(8'h2A, 1, 8'h2A, 0, 0, 3'b000, 0);
    add_p(8'hAA); add_p(8'hFA);
    add_p(8'hE0); add_p(8'hE0);
    add_v(8'h75, 1, 8'h75, 1, 0, 3'b000, 0);
    add_p(8'hF0); add_p(8'hF0);
    add_v(8'h75, 1, 8'h75, 0, 1, 3'b000, 0);
    add_p(8'hF0); add_p(8'hE0);
    add_v(8'h75, 1, 8'h75, 1, 1, 3'b000, 0);
    add_p(8'hE1);
    add_v(8'h00, 0, 8'h00, 0, 0, 3'b000, 1);
    add_v(8'h1B, 1, 8'h1B, 0, 0, 3'b000, 0);

    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("after_reset");

    foreach (tbl[i]) begin
      if (tbl[i].emit) exp_emit(tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].mod);
      if (tbl[i].err) err_exp++;
      send(tbl[i].b);
      check_step($sformatf("vec%0d_%02h", i, tbl[i].b));
    end

    // Prefix abandoned after exactly TO idle clocks: error, then plain make.
    pulse(8'hE0);
    repeat (TO - 1) @(negedge clk);
    err_exp++;
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
    send(8'h1C);
    check_step("timeout_expire");

    // Byte lands on the expiry clock: processed as extended, no error.
    pulse(8'hE0);
    repeat (TO - 2) @(negedge clk);
    exp_emit(8'h1C, 1'b1, 1'b0, 3'b000);
    send(8'h1C);
    check_step("timeout_coincide");

    // Reset mid-sequence drops the E0 prefix silently.
    pulse(8'hE0);
    rst_n = 1'b0;
    show_exp = 24'h0;
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_step("mid_reset_quiet");

    // Typematic repeat sequence.
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
    send(8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
`endif
    send(8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
`endif
    send(8'h1C);
    send(8'hF0);
    exp_emit(8'h1C, 1'b0, 1'b1, 3'b000);
    send(8'h1C);
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
    send(8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
    exp_emit(8'h1C, 1'b0, 1'b0, 3'b000);
`endif
    send(8'h1C);
    repeat (TO + 5) @(negedge clk);
    check_step("repeat_seq");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
